// File: rtl/uart_phy_rx.sv
// uart_phy_rx: receive-side UART PHY. Oversamples rxd_i and walks the
// Idle/Start/Data/Parity/Stop1/Stop2 frame sequence. Each received byte is
// pushed to the FIFO with its error flags as a one-cycle rx_valid_o strobe.
// Optional build macro UART_RX_MAJORITY_EN: every bit is the 2-of-3 majority
// of three consecutive ticks around mid-bit, decided one tick later.
module uart_phy_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 rxen_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 nstop_i,
  input  logic                 parity_en_i,
  input  logic                 parity_odd_i,
  input  logic                 rxd_i,
  output logic [7:0]           rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 busy_o
);

  localparam int SW = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif
  // Start bit is decided mid-bit; every later bit a full bit time after that.
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE/2 - 1 + LAG);
  localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP1, S_STOP2
  } state_t;

  state_t                 state_q;
  logic [DIV_WIDTH-1:0]   ccnt_q;
  logic [SW-1:0]          scnt_q;
  logic [2:0]             bcnt_q;
  logic [7:0]             shift_q;
  logic                   armed_q;
  logic                   nstop_q, pen_q, podd_q;
  logic                   perr_q, ferr_q;

  logic tick, start_go, sample_pt, bit_s;

  assign tick      = (ccnt_q == div_i);
  assign start_go  = (state_q == S_IDLE) && rxen_i && armed_q && !rxd_i;
  assign sample_pt = tick && (scnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep rxd from the previous two ticks for the 2-of-3 vote.
  always_ff @(posedge clock_i) begin
    if (reset_i)   hist_q <= '0;
    else if (tick) hist_q <= {hist_q[0], rxd_i};
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxd_i) | (hist_q[0] & rxd_i);
`else
  assign bit_s = rxd_i;
`endif

  // Oversample tick generator; phase realigned to the start edge.
  always_ff @(posedge clock_i) begin
    if (reset_i || start_go) ccnt_q <= '0;
    else if (tick)           ccnt_q <= '0;
    else                     ccnt_q <= ccnt_q + 1'b1;
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      scnt_q         <= '0;
      bcnt_q         <= '0;
      shift_q        <= '0;
      armed_q        <= 1'b0;
      nstop_q        <= 1'b0;
      pen_q          <= 1'b0;
      podd_q         <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      rx_data_o      <= '0;
      rx_valid_o     <= 1'b0;
      parity_error_o <= 1'b0;
      frame_error_o  <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (state_q != S_IDLE && !rxen_i) begin
        // Abort: drop the partial frame, keep the last delivered outputs.
        state_q <= S_IDLE;
        busy_o  <= 1'b0;
        armed_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // A line that never went high since the last frame is a break.
            if (rxd_i) armed_q <= 1'b1;
            if (start_go) begin
              state_q <= S_START;
              busy_o  <= 1'b1;
              armed_q <= 1'b0;
              scnt_q  <= '0;
              perr_q  <= 1'b0;
              ferr_q  <= 1'b0;
              nstop_q <= nstop_i;
              pen_q   <= parity_en_i;
              podd_q  <= parity_odd_i;
            end
          end
          default: begin
            if (tick) scnt_q <= scnt_q + 1'b1;
            if (sample_pt) begin
              scnt_q <= '0;
              case (state_q)
                S_START: begin
                  if (bit_s) begin
                    state_q <= S_IDLE;
                    busy_o  <= 1'b0;
                  end else begin
                    state_q <= S_DATA;
                    bcnt_q  <= '0;
                  end
                end
                S_DATA: begin
                  shift_q <= {bit_s, shift_q[7:1]};
                  bcnt_q  <= bcnt_q + 3'd1;
                  if (bcnt_q == 3'd7) state_q <= pen_q ? S_PAR : S_STOP1;
                end
                S_PAR: begin
                  perr_q  <= ((^shift_q) ^ bit_s) != podd_q;
                  state_q <= S_STOP1;
                end
                S_STOP1: begin
                  if (nstop_q) begin
                    ferr_q  <= ~bit_s;
                    state_q <= S_STOP2;
                  end else begin
                    rx_data_o      <= shift_q;
                    rx_valid_o     <= 1'b1;
                    parity_error_o <= pen_q & perr_q;
                    frame_error_o  <= ~bit_s;
                    state_q        <= S_IDLE;
                    busy_o         <= 1'b0;
                  end
                end
                S_STOP2: begin
                  rx_data_o      <= shift_q;
                  rx_valid_o     <= 1'b1;
                  parity_error_o <= pen_q & perr_q;
                  frame_error_o  <= ferr_q | ~bit_s;
                  state_q        <= S_IDLE;
                  busy_o         <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_phy_rx.sv
// tb_uart_phy_rx: drives whole UART frames bit by bit and compares every
// delivered byte and error flag against a frame-level expectation queue.
module tb_uart_phy_rx;
  localparam int OS = 16;

  logic        clk = 1'b0;
  logic        rst, rxen, nstop, pen, podd, rxd;
  logic [15:0] div;
  logic [7:0]  rx_data;
  logic        rx_valid, parity_error, frame_error, busy;

  uart_phy_rx #(.OVERSAMPLE(OS), .DIV_WIDTH(16)) dut (
    .clock_i(clk), .reset_i(rst), .rxen_i(rxen), .div_i(div),
    .nstop_i(nstop), .parity_en_i(pen), .parity_odd_i(podd), .rxd_i(rxd),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .parity_error_o(parity_error),
    .frame_error_o(frame_error), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; logic pe; logic fe; longint t; } rec_t;
  rec_t   got_q[$];
  rec_t   exp_q[$];
  longint cyc = 0;
  longint t_fall = 0;
  logic [7:0] last_d = 8'h00;
  int n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every push away from the active edge.
  always @(negedge clk)
    if (rx_valid) got_q.push_back('{d: rx_data, pe: parity_error, fe: frame_error, t: cyc});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Compare captured pushes against expected frames, then clear both.
  task automatic check_sb(input string tag);
    rec_t g, e;
    chk({tag, "_cnt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"}, g.d, e.d);
      chk({tag, "_pe"}, g.pe, e.pe);
      chk({tag, "_fe"}, g.fe, e.fe);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Send one frame using the current line config. ab_bit>=0 aborts in the
  // middle of that data bit: ab_kind 1 drops rxen, 2 pulses reset.
  task automatic send_frame(input logic [7:0] b, input logic pflip, input logic s1,
                            input logic s2, input int gap_bits, input int ab_bit,
                            input int ab_kind);
    logic bq[$];
    int   bt;
    rec_t e;
    bt = OS * (int'(div) + 1);
    bq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bq.push_back(b[i]);
    if (pen) bq.push_back((^b) ^ podd ^ pflip);
    bq.push_back(s1);
    if (nstop) bq.push_back(s2);
    t_fall = cyc;
    for (int k = 0; k < bq.size(); k++) begin
      rxd = bq[k];
      if (ab_bit >= 0 && k == ab_bit + 1) begin
        clks(bt / 2);
        if (ab_kind == 1) begin
          rxen = 1'b0;
          clks(1);
          chk("abort_busy", busy, 0);
          chk("abort_hold", rx_data, last_d);
        end else begin
          rst = 1'b1;
          clks(1);
          rst = 1'b0;
          chk("rst_data", rx_data, 0);
          chk("rst_busy", busy, 0);
          chk("rst_flags", {rx_valid, parity_error, frame_error}, 0);
          last_d = 8'h00;
        end
        clks(bt - bt / 2 - 1);
      end else begin
        clks(bt);
      end
    end
    rxd = 1'b1;
    clks(gap_bits * bt);
    if (ab_bit < 0) begin
      e.d  = b;
      e.pe = pen & pflip;
      e.fe = ~s1 | (nstop & ~s2);
      e.t  = 0;
      exp_q.push_back(e);
      last_d = b;
    end
  endtask

  initial begin
    longint lat;
    rst = 1'b1; rxen = 1'b1; div = 16'd0; nstop = 1'b0; pen = 1'b0; podd = 1'b0; rxd = 1'b1;
    clks(3);
    chk("reset_data", rx_data, 0);
    chk("reset_flags", {rx_valid, parity_error, frame_error, busy}, 0);
    rst = 1'b0;
    clks(4);

    // 8N1 0xA5 at div=0, including push latency from the falling edge
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 2, -1, 0);
    lat = (got_q.size() > 0) ? (got_q[0].t - t_fall) : 0;
    chk("a5_latency_ok", (lat >= 150 && lat <= 154), 1);
    chk("a5_busy", busy, 0);
    check_sb("a5");

    // Odd parity, two stop bits, div=3: good then flipped parity bit
    div = 16'd3; pen = 1'b1; podd = 1'b1; nstop = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1, -1, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1, -1, 0);
    check_sb("par");

    // Break: 40 low bit times yield exactly one frame-error byte
    div = 16'd0; pen = 1'b0; nstop = 1'b0;
    rxd = 1'b0;
    clks(40 * OS);
    rxd = 1'b1;
    clks(3 * OS);
    exp_q.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1, t: 0});
    last_d = 8'h00;
    check_sb("brk");
    send_frame(8'h96, 1'b0, 1'b1, 1'b1, 1, -1, 0);
    check_sb("post_brk");

    // Glitch: 3-clock low pulse is rejected, following frame received
    rxd = 1'b0;
    clks(3);
    rxd = 1'b1;
    clks(2 * OS);
    chk("glitch_busy", busy, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 2, -1, 0);
    check_sb("glitch");

    // Abort by rxen during data bit 4, then by reset
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2, 4, 1);
    rxen = 1'b1;
    clks(OS);
    check_sb("abort_rxen");
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 2, 4, 2);
    check_sb("abort_rst");

    // Back-to-back 8N2 frames with no idle gap
    div = 16'd1; nstop = 1'b1;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, -1, 0);
    send_frame(8'h80, 1'b0, 1'b1, 1'b1, 0, -1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 2, -1, 0);
    check_sb("b2b");

    // Random frames with random config and injected errors
    for (int n = 0; n < 30; n++) begin
      div   = 16'($urandom_range(0, 2));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      nstop = 1'($urandom_range(0, 1));
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                 1 + int'($urandom_range(0, 1)), -1, 0);
      check_sb("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_phy_rx.md
Name: uart_phy_rx

Overview:
- Receive-side UART physical layer. Consumes the serial line, oversamples it and walks the Idle/Start/Data/Parity/Stop1/Stop2 frame sequence.
- Delivers each received byte plus per-frame error flags to the RX FIFO / register block as a one-cycle push.
- Counterpart of the TX PHY. The bench drives it with the RxTask* sequence.

Parameters:
- OVERSAMPLE, 16: oversample ticks per bit. Even, ≥4.
- DIV_WIDTH, 16: width of the baud divisor input.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rxen  in  1  receiver enable.
- div  in  DIV_WIDTH  oversample tick period minus 1, in clocks (tick every div+1 cycles).
- nstop  in  1  0 = one stop bit, 1 = two stop bits.
- parity_en  in  1  parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- rxd  in  1  serial input, already 2-flop synchronized in the UART top.
- rx_data  out  8  received byte.
- rx_valid  out  1  one-cycle push strobe to the FIFO.
- parity_error  out  1  qualified by rx_valid.
- frame_error  out  1  qualified by rx_valid. Stop bit sampled low.
- busy  out  1  high in any state other than Idle.

Behaviour:
- **Reset values:** state=Idle, rx_data=0, rx_valid=0, parity_error=0, frame_error=0, busy=0, all counters 0, armed=0.
- **Tick generator:** clock counter 0..div. A tick fires when counter==div, then the counter returns to 0. The counter is zeroed on entry to Start so tick phase is aligned to the start edge. div=0 means a tick every clock.
- **Sample counter:** counts ticks within a bit, 0..OVERSAMPLE-1.
- **Idle:**
  - armed is set when rxd=1 is seen.
  - If rxen=1, armed=1 and rxd=0, go to Start the next cycle.
  - nstop, parity_en and parity_odd are latched at this transition. Changes mid-frame have no effect.
- **Start:**
  - After OVERSAMPLE/2 ticks, sample rxd.
  - If rxd=1 (glitch): go to Idle, no output.
  - Else: sample counter cleared, go to Data.
- **Data:**
  - Every OVERSAMPLE ticks, sample one bit, LSB first, into the shift register.
  - After the 8th bit: go to Parity if parity_en, else Stop1.
- **Parity:**
  - After OVERSAMPLE ticks, sample the parity bit.
  - parity_error = (XOR of data ^ sampled bit) != parity_odd.
  - Go to Stop1.
- **Stop1:**
  - After OVERSAMPLE ticks, sample rxd. frame_error = ~rxd.
  - If nstop: go to Stop2.
  - Else: issue the output and go to Idle.
- **Stop2:**
  - After OVERSAMPLE ticks, sample rxd. frame_error |= ~rxd.
  - Issue the output, go to Idle.
- **Output issue:**
  - rx_valid=1 for exactly one cycle, the cycle after the final stop sample.
  - rx_data, parity_error and frame_error are updated in the same cycle and held until the next issue.
  - A frame with errors is still delivered.
- **Break / low line:** after any frame, armed is cleared. Idle does not start a new frame until rxd=1 has been seen, so a held-low line yields exactly one frame_error byte.
- **rxen=0 mid-frame:** return to Idle the next cycle, no rx_valid, previous outputs held.
- **reset mid-frame:** all values return to reset values next cycle, no output.
- **No backpressure:** overrun is handled by the FIFO.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- When defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rxd sampled on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit. The decision is made at tick OVERSAMPLE/2+1, and all timing shifts by one tick.
- When undefined: a single sample at tick OVERSAMPLE/2.

Test Plan:
- **8N1 byte:** div=0, nstop=0, parity_en=0; send 0xA5 with a falling edge at cycle 0 -> one rx_valid pulse ~152 clocks later (±2), rx_data=0xA5, parity_error=0, frame_error=0, busy low afterward.
- **Odd parity:** div=3, parity_en=1, parity_odd=1, nstop=1; send 0x3C with parity bit 1 -> rx_data=0x3C, no errors. Resend with parity bit 0 -> parity_error=1, data still 0x3C.
- **Frame error and break:** hold rxd=0 for 40 bit times -> exactly one rx_valid with rx_data=0x00 and frame_error=1. No further pulses until rxd returns high and a new start bit arrives.
- **Glitch rejection:** 3-clock low pulse on rxd, div=0 -> return to Idle, no rx_valid. A following valid 0x5A is received correctly.
- **Abort:** drop rxen during Data bit 4 of 0xFF -> no rx_valid, busy=0 next cycle. Assert reset mid-frame -> all outputs 0.
- **Back-to-back frames:** 0x01, 0x80, 0x55 with no idle gap, 8N2 -> three rx_valid pulses with matching data, no errors.
